// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   mode_t    : 3-bit shift-mode field carried on in_mode and through the pipe
//   MODE_*    : legal mode encodings; 3'b101..3'b111 are illegal
package shift_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_SLL = 3'b000;  // logical left, zero fill
   localparam mode_t MODE_SRL = 3'b001;  // logical right, zero fill
   localparam mode_t MODE_SRA = 3'b010;  // arithmetic right, sign fill
   localparam mode_t MODE_ROL = 3'b011;  // rotate left
   localparam mode_t MODE_ROR = 3'b100;  // rotate right

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts/rotates by 2**LEVEL
// when sel is set, and ORs the bits dropped off the low end into the sticky
// bit for the right-shift modes. Illegal modes pass data through untouched.
//   data_in    : operand from the previous level / pipeline register
//   sel        : shift-amount bit LEVEL
//   mode       : shift mode (shift_pkg encoding)
//   sticky_in  : sticky accumulated by earlier levels
//   data_out   : result of this level
//   sticky_out : sticky including bits lost at this level
module shift_level
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned LEVEL = 0
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic             sel,
   input  mode_t            mode,
   input  logic             sticky_in,
   output logic [WIDTH-1:0] data_out,
   output logic             sticky_out
);

   localparam int unsigned SH = 2**LEVEL;
   // Mask of the SH low bits; SH == WIDTH yields an all-ones mask.
   localparam logic [WIDTH:0]   ONE_SH   = (WIDTH+1)'(1) << SH;
   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(ONE_SH - 1'b1);

   logic [WIDTH-1:0] sll_v;
   logic [WIDTH-1:0] srl_v;
   logic [WIDTH-1:0] sra_v;
   logic [WIDTH-1:0] rol_v;
   logic [WIDTH-1:0] ror_v;
   logic             lost;

   always_comb begin
      sll_v = data_in << SH;
      srl_v = data_in >> SH;
      sra_v = $signed(data_in) >>> SH;
      rol_v = (data_in << SH) | (data_in >> (WIDTH - SH));
      ror_v = (data_in >> SH) | (data_in << (WIDTH - SH));
      lost  = |(data_in & LOW_MASK);

      data_out   = data_in;
      sticky_out = sticky_in;
      if (sel) begin
         case (mode)
            MODE_SLL: data_out = sll_v;
            MODE_SRL: begin
               data_out   = srl_v;
               sticky_out = sticky_in | lost;
            end
            MODE_SRA: begin
               data_out   = sra_v;
               sticky_out = sticky_in | lost;
            end
            MODE_ROL: data_out = rol_v;
            MODE_ROR: data_out = ror_v;
            default:  data_out = data_in;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROL/ROR) with sticky output.
// SHW mux levels, a register after every LVL_PER_REG levels and after the last
// one; the last register drives out_*. Global stall: all stages advance
// together when the output register is empty or being consumed.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake (in_ready is combinational)
//   in_data/amt/mode/tag : operand, unsigned amount, mode, sideband tag
//   out_valid/out_ready: output handshake
//   out_data/sticky    : result and OR of bits shifted out (SRL/SRA)
//   out_err            : illegal mode (data passed through unchanged)
//   out_tag            : tag of this result
module pipelined_barrel_shifter
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned SHW         = 5,
   parameter int unsigned LVL_PER_REG = 2,
   parameter int unsigned TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  mode_t            in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sticky,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned R = (SHW + LVL_PER_REG - 1) / LVL_PER_REG;

   logic [R-1:0]     valid_q, valid_d;
   logic [R-1:0]     sticky_q, sticky_d;
   logic [WIDTH-1:0] data_q [R];
   logic [WIDTH-1:0] data_d [R];
   mode_t            mode_q [R];
   mode_t            mode_d [R];
   logic [SHW-1:0]   amt_q  [R];
   logic [SHW-1:0]   amt_d  [R];
   logic [TAG_W-1:0] tag_q  [R];
   logic [TAG_W-1:0] tag_d  [R];

   logic [WIDTH-1:0] stage_data [R];
   logic [R-1:0]     stage_sticky;

   logic             adv;
   logic [SHW:0]     amt_ext;
   logic [SHW-1:0]   amt_eff;
   logic             unused_amt;

   // Rotates: one conditional subtract brings the amount below WIDTH.
   // SRA: any amount past WIDTH-1 gives the same all-sign result, so clamp;
   // this also keeps sign copies from ever reaching the sticky OR.
   always_comb begin
      amt_ext = {1'b0, in_amt};
      amt_eff = in_amt;
      if ((in_mode == MODE_ROL || in_mode == MODE_ROR) && amt_ext >= (SHW+1)'(WIDTH)) begin
         amt_eff = SHW'(amt_ext - (SHW+1)'(WIDTH));
      end else if (in_mode == MODE_SRA && amt_ext > (SHW+1)'(WIDTH - 1)) begin
         amt_eff = SHW'(WIDTH - 1);
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_lvl
      localparam int unsigned ST = k / LVL_PER_REG;
      logic [WIDTH-1:0] lin;
      logic             sin;
      mode_t            lmode;
      logic             lsel;
      logic [WIDTH-1:0] lout;
      logic             sout;

      if (ST == 0) begin : g_ctl_in
         assign lmode = in_mode;
         assign lsel  = amt_eff[k];
      end else begin : g_ctl_reg
         assign lmode = mode_q[ST-1];
         assign lsel  = amt_q[ST-1][k];
      end

      if (k == 0) begin : g_src_in
         assign lin = in_data;
         assign sin = 1'b0;
      end else if (k % LVL_PER_REG == 0) begin : g_src_reg
         assign lin = data_q[ST-1];
         assign sin = sticky_q[ST-1];
      end else begin : g_src_chain
         assign lin = g_lvl[k-1].lout;
         assign sin = g_lvl[k-1].sout;
      end

      shift_level #(
         .WIDTH (WIDTH),
         .LEVEL (k)
      ) u_level (
         .data_in    (lin),
         .sel        (lsel),
         .mode       (lmode),
         .sticky_in  (sin),
         .data_out   (lout),
         .sticky_out (sout)
      );
   end

   for (genvar r = 0; r < R; r++) begin : g_stage
      localparam int unsigned LAST = ((r + 1) * LVL_PER_REG < SHW) ?
                                     (r + 1) * LVL_PER_REG - 1 : SHW - 1;
      assign stage_data[r]   = g_lvl[LAST].lout;
      assign stage_sticky[r] = g_lvl[LAST].sout;
   end

   always_comb begin
      adv      = !valid_q[R-1] || out_ready;
      in_ready = adv;
   end

   always_comb begin
      valid_d  = valid_q;
      sticky_d = sticky_q;
      data_d   = data_q;
      mode_d   = mode_q;
      amt_d    = amt_q;
      tag_d    = tag_q;
      if (adv) begin
         valid_d[0]  = in_valid;
         sticky_d[0] = stage_sticky[0];
         data_d[0]   = stage_data[0];
         mode_d[0]   = in_mode;
         amt_d[0]    = amt_eff;
         tag_d[0]    = in_tag;
         for (int unsigned r = 1; r < R; r++) begin
            valid_d[r]  = valid_q[r-1];
            sticky_d[r] = stage_sticky[r];
            data_d[r]   = stage_data[r];
            mode_d[r]   = mode_q[r-1];
            amt_d[r]    = amt_q[r-1];
            tag_d[r]    = tag_q[r-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         sticky_q <= '0;
         for (int unsigned r = 0; r < R; r++) begin
            data_q[r] <= '0;
            mode_q[r] <= MODE_SLL;
            amt_q[r]  <= '0;
            tag_q[r]  <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         sticky_q <= sticky_d;
         data_q   <= data_d;
         mode_q   <= mode_d;
         amt_q    <= amt_d;
         tag_q    <= tag_d;
      end
   end

   // Amount bits of levels already passed are carried but not read again.
   always_comb begin
      unused_amt = 1'b0;
      for (int unsigned r = 0; r < R; r++) begin
         unused_amt = unused_amt ^ (^amt_q[r]);
      end
   end

   // Illegal modes leave data and sticky untouched in every level, so the
   // error flag only needs the mode carried to the output register.
   always_comb begin
      out_valid  = valid_q[R-1];
      out_data   = data_q[R-1];
      out_sticky = sticky_q[R-1];
      out_err    = mode_q[R-1] > MODE_ROR;
      out_tag    = tag_q[R-1];
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomised checks of pipelined_barrel_shifter (24-bit, R = 3).
module tb_pipelined_barrel_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_data;
   logic [4:0]  in_amt;
   logic [2:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic        out_sticky;
   logic        out_err;
   logic [3:0]  out_tag;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [23:0] data;
      logic        sticky;
      logic        err;
      logic [3:0]  tag;
   } exp_t;

   pipelined_barrel_shifter #(
      .WIDTH       (24),
      .SHW         (5),
      .LVL_PER_REG (2),
      .TAG_W       (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_amt     (in_amt),
      .in_mode    (in_mode),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sticky (out_sticky),
      .out_err    (out_err),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   // Reference: whole-word arithmetic, independent of the level structure.
   function automatic exp_t model(input logic [23:0] d, input logic [4:0] a,
                                  input logic [2:0] m, input logic [3:0] t);
      exp_t        r;
      logic [47:0] dd;
      logic [23:0] msk;
      int          sa;
      r.data   = d;
      r.sticky = 1'b0;
      r.err    = 1'b0;
      r.tag    = t;
      sa       = int'(a);
      case (m)
         3'd0: r.data = (sa >= 24) ? 24'h0 : d << sa;
         3'd1: begin
            if (sa >= 24) begin
               r.data   = 24'h0;
               r.sticky = |d;
            end else begin
               msk      = (24'h1 << sa) - 24'h1;
               r.data   = d >> sa;
               r.sticky = |(d & msk);
            end
         end
         3'd2: begin
            if (sa > 23) sa = 23;
            msk      = (24'h1 << sa) - 24'h1;
            r.data   = $signed(d) >>> sa;
            r.sticky = |(d & msk);
         end
         3'd3: begin
            if (sa >= 24) sa = sa - 24;
            dd     = {d, d} << sa;
            r.data = dd[47:24];
         end
         3'd4: begin
            if (sa >= 24) sa = sa - 24;
            dd     = {d, d} >> sa;
            r.data = dd[23:0];
         end
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 24'h0) begin bad++; $display("FAIL reset_data: got %h want 000000", out_data); end
      total++; if (out_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b want 0", out_sticky); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", out_err); end
      total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag: got %h want 0", out_tag); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  v_m [18] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd7, 3'd1, 3'd1,
                                3'd2, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd5, 3'd3, 3'd0};
      logic [23:0] v_d [18] = '{24'h000001, 24'h000001, 24'h000003, 24'h800000, 24'h000001,
                                24'hC00000, 24'h123456, 24'hABCDEF, 24'h000001, 24'h7FFFFF,
                                24'h900001, 24'h123456, 24'h123456, 24'h123456, 24'h800000,
                                24'hABCDEF, 24'h000001, 24'hFFFFFF};
      logic [4:0]  v_a [18] = '{5'd23, 5'd24, 5'd1, 5'd31, 5'd25, 5'd2, 5'd5, 5'd0, 5'd24,
                                5'd24, 5'd4, 5'd0, 5'd4, 5'd8, 5'd31, 5'd3, 5'd31, 5'd1};
      logic [23:0] v_q [18] = '{24'h800000, 24'h000000, 24'h000001, 24'hFFFFFF, 24'h800000,
                                24'h000003, 24'h123456, 24'hABCDEF, 24'h000000, 24'h000000,
                                24'hF90000, 24'h123456, 24'h612345, 24'h345600, 24'h000000,
                                24'hABCDEF, 24'h000080, 24'hFFFFFE};
      logic        v_s [18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic        v_e [18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         in_valid = 1'b1; in_data = v_d[i]; in_amt = v_a[i]; in_mode = v_m[i]; in_tag = 4'(i);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid: got %b want 1", i, out_valid); end
         total++; if (out_data !== v_q[i]) begin bad++; $display("FAIL dir%0d_data: got %h want %h", i, out_data, v_q[i]); end
         total++; if (out_sticky !== v_s[i]) begin bad++; $display("FAIL dir%0d_sticky: got %b want %b", i, out_sticky, v_s[i]); end
         total++; if (out_err !== v_e[i]) begin bad++; $display("FAIL dir%0d_err: got %b want %b", i, out_err, v_e[i]); end
         total++; if (out_tag !== 4'(i)) begin bad++; $display("FAIL dir%0d_tag: got %h want %h", i, out_tag, 4'(i)); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int          sent = 0;
      int          got  = 0;
      logic        held = 1'b0;
      logic [23:0] prev_data = '0;
      logic [3:0]  prev_tag  = '0;
      for (int c = 0; c < 60; c++) begin
         in_valid = (sent < 6);
         in_data  = 24'h000001;
         in_amt   = 5'(sent);
         in_mode  = 3'd0;
         in_tag   = 4'(sent);
         out_ready = !(c >= 3 && c < 8);
         @(negedge clk);
         if (out_valid && !out_ready) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_c%0d: got %b want 0", c, in_ready); end
            if (held) begin
               total++; if (out_data !== prev_data) begin bad++; $display("FAIL b2b_hold_data_c%0d: got %h want %h", c, out_data, prev_data); end
               total++; if (out_tag !== prev_tag) begin bad++; $display("FAIL b2b_hold_tag_c%0d: got %h want %h", c, out_tag, prev_tag); end
            end
            held = 1'b1; prev_data = out_data; prev_tag = out_tag;
         end else begin
            held = 1'b0;
         end
         if (out_valid && out_ready) begin
            total++; if (out_tag !== 4'(got)) begin bad++; $display("FAIL b2b_order: got %h want %h", out_tag, 4'(got)); end
            total++; if (out_data !== (24'h000001 << got)) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", got, out_data, 24'h000001 << got); end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         if (got == 6 && sent == 6) break;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (got != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", got); end
      repeat (4) begin
         @(negedge clk);
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra_valid: got %b want 0", out_valid); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 24'h800000; in_amt = 5'(i + 1); in_mode = 3'd2; in_tag = 4'(i + 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 24'h0) begin bad++; $display("FAIL mid_rst_data: got %h want 000000", out_data); end
      total++; if (out_sticky !== 1'b0) begin bad++; $display("FAIL mid_rst_sticky: got %b want 0", out_sticky); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", out_err); end
      total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL mid_rst_tag: got %h want 0", out_tag); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_ghost%0d: got %b want 0", i, out_valid); end
      end
      in_valid = 1'b1; in_data = 24'h000001; in_amt = 5'd1; in_mode = 3'd4; in_tag = 4'h9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_new_early: got %b want 0", out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_new_valid: got %b want 1", out_valid); end
      total++; if (out_data !== 24'h800000) begin bad++; $display("FAIL mid_new_data: got %h want 800000", out_data); end
      total++; if (out_tag !== 4'h9) begin bad++; $display("FAIL mid_new_tag: got %h want 9", out_tag); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int   got = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 24'($urandom);
         in_amt    = 5'($urandom_range(0, 31));
         in_mode   = 3'($urandom_range(0, 7));
         in_tag    = 4'(c);
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL rnd_unexpected: got tag %h want no output", out_tag);
            end else begin
               e = q.pop_front();
               if (out_data !== e.data) begin bad++; $display("FAIL rnd_data%0d: got %h want %h", got, out_data, e.data); end
               total++; if (out_sticky !== e.sticky) begin bad++; $display("FAIL rnd_sticky%0d: got %b want %b", got, out_sticky, e.sticky); end
               total++; if (out_err !== e.err) begin bad++; $display("FAIL rnd_err%0d: got %b want %b", got, out_err, e.err); end
               total++; if (out_tag !== e.tag) begin bad++; $display("FAIL rnd_tag%0d: got %h want %h", got, out_tag, e.tag); end
               got++;
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_data, in_amt, in_mode, in_tag));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
         @(negedge clk);
         if (out_valid) begin
            e = q.pop_front();
            total++; if (out_data !== e.data) begin bad++; $display("FAIL rnd_drain_data: got %h want %h", out_data, e.data); end
            total++; if (out_sticky !== e.sticky) begin bad++; $display("FAIL rnd_drain_sticky: got %b want %b", out_sticky, e.sticky); end
            total++; if (out_tag !== e.tag) begin bad++; $display("FAIL rnd_drain_tag: got %h want %h", out_tag, e.tag); end
         end
         @(posedge clk); #1;
      end
      total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_left: got %0d pending want 0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "simulation timeout");
   end

endmodule
